// File: rtl/piezo_pkg.sv
// piezo_pkg: shared types and constants for the piezo tune sequencer.
//   note_t     - one ROM entry: period in clocks (0 = rest), duration, last-note flag
//   rom_t      - 16-entry note table type
//   NOTE_ROM   - default tune table (fanfare at 0, battery-low at 6)
//   TUNE_START - first ROM entry of each tune, indexed by tune number
//   state_t    - sequencer states
package piezo_pkg;

    typedef struct packed {
        logic [14:0] frq;
        logic [24:0] dur;
        logic        last;
    } note_t;

    typedef note_t [15:0] rom_t;

    localparam logic [14:0] G6 = 15'd31888;
    localparam logic [14:0] C7 = 15'd23889;
    localparam logic [14:0] E7 = 15'd18961;
    localparam logic [14:0] G7 = 15'd15944;
    localparam logic [24:0] D1 = 25'd8388608;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_PLAY = 2'd2
    } state_t;

    function automatic note_t mk_note(input logic [14:0] f, input logic [24:0] d,
                                      input logic l);
        note_t n;
        n.frq  = f;
        n.dur  = d;
        n.last = l;
        return n;
    endfunction

    function automatic rom_t build_rom();
        rom_t r;
        r     = '0;
        // fanfare
        r[0]  = mk_note(G6, D1, 1'b0);
        r[1]  = mk_note(C7, D1, 1'b0);
        r[2]  = mk_note(E7, D1, 1'b0);
        r[3]  = mk_note(G7, D1 + (D1 >> 1), 1'b0);
        r[4]  = mk_note(E7, D1 >> 1, 1'b0);
        r[5]  = mk_note(G7, D1 << 1, 1'b1);
        // battery low, ends on a rest
        r[6]  = mk_note(G6, D1, 1'b0);
        r[7]  = mk_note(C7, D1, 1'b0);
        r[8]  = mk_note(E7, D1, 1'b0);
        r[9]  = mk_note(15'd0, D1, 1'b1);
        return r;
    endfunction

    localparam rom_t NOTE_ROM = build_rom();

    localparam logic [1:0][3:0] TUNE_START = {4'd6, 4'd0};

endpackage

// File: rtl/piezo_tone.sv
// piezo_tone: square-wave generator for one note.
//   i_frq     - note period in clocks; 0 = rest (both outputs low)
//   i_clr     - note start: counter restarts at 0 on this edge
//   i_en      - keep sounding; when neither i_clr nor i_en, outputs go low
//   o_piezo   - registered (cnt >= frq/2)
//   o_piezo_n - registered complement while sounding, low during rests
module piezo_tone #(
    parameter int FRQ_W = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [FRQ_W-1:0] i_frq,
    input  logic             i_clr,
    input  logic             i_en,
    output logic             o_piezo,
    output logic             o_piezo_n
);

    logic [FRQ_W-1:0] r_cnt;
    logic [FRQ_W-1:0] w_cnt_nx;
    logic             r_piezo;
    logic             r_piezo_n;
    logic             w_on;
    logic             w_high;

    assign w_on = |i_frq;

    // Outputs are registered from the next count, so the registered level
    // always matches the compare of the count value visible in that cycle.
    always_comb begin
        w_cnt_nx = '0;
        if (!i_clr && w_on && (r_cnt < i_frq - 1'b1))
            w_cnt_nx = r_cnt + 1'b1;
    end

    assign w_high = (w_cnt_nx >= (i_frq >> 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_piezo   <= 1'b0;
            r_piezo_n <= 1'b0;
        end else if (i_clr || i_en) begin
            r_cnt     <= w_cnt_nx;
            r_piezo   <= w_on && w_high;
            r_piezo_n <= w_on && !w_high;
        end else begin
            r_cnt     <= '0;
            r_piezo   <= 1'b0;
            r_piezo_n <= 1'b0;
        end
    end

    assign o_piezo   = r_piezo;
    assign o_piezo_n = r_piezo_n;

endmodule

// File: rtl/piezo_seq.sv
// piezo_seq: table-driven multi-tune piezo sequencer.
// Optional feature macro: PIEZO_PREEMPT_EN (higher-index request aborts the
// playing tune and starts the new one).
//   i_play_req - level requests, one bit per tune, highest index wins
//   i_stop     - abort to silence, no done pulse
//   o_piezo / o_piezo_n - differential transducer drive, both low when silent
//   o_busy     - high in LOAD and PLAY
//   o_tune_idx - tune being played, held in IDLE
//   o_done     - one-cycle pulse when a tune ends on its last note
//
// state | meaning
// IDLE  | silent, waiting for a request
// LOAD  | latch note at note_ptr, clear counters
// PLAY  | sound note until its duration is reached
module piezo_seq
    import piezo_pkg::*;
#(
    parameter int NUM_TUNES = 2,
    parameter int FRQ_W     = 15,
    parameter int DUR_W     = 25,
    parameter int ROM_DEPTH = 16,
    parameter int FAST_SIM  = 0,
    parameter note_t [ROM_DEPTH-1:0] P_NOTE_ROM = NOTE_ROM,
    parameter logic [NUM_TUNES-1:0][$clog2(ROM_DEPTH)-1:0] P_TUNE_START = TUNE_START
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_TUNES-1:0]         i_play_req,
    input  logic                         i_stop,
    output logic                         o_piezo,
    output logic                         o_piezo_n,
    output logic                         o_busy,
    output logic [$clog2(NUM_TUNES)-1:0] o_tune_idx,
    output logic                         o_done
);

    localparam int PTR_W = $clog2(ROM_DEPTH);
    localparam int IDX_W = $clog2(NUM_TUNES);
    localparam logic [DUR_W:0] DUR_INC = (FAST_SIM != 0) ? (DUR_W+1)'(16) : (DUR_W+1)'(1);

    state_t           r_state, w_state_nx;
    logic [PTR_W-1:0] r_ptr, w_ptr_nx;
    logic [IDX_W-1:0] r_idx, w_idx_nx;
    logic             r_done, w_done_nx;
    logic [FRQ_W-1:0] r_frq;
    logic [DUR_W-1:0] r_dur;
    logic             r_last;
    // One spare bit so the +16 step past a near-full duration cannot wrap.
    logic [DUR_W:0]   r_cnt_dur;
    logic             w_dur_hit;
    logic             w_any_req;
    logic [IDX_W-1:0] w_req_idx;
    note_t            w_note;
    logic [FRQ_W-1:0] w_tone_frq;
    logic             w_tone_clr;
    logic             w_tone_en;

    assign w_note    = P_NOTE_ROM[r_ptr];
    assign w_any_req = |i_play_req;
    assign w_dur_hit = (r_cnt_dur >= {1'b0, r_dur});

    always_comb begin
        w_req_idx = '0;
        for (int i = 0; i < NUM_TUNES; i++)
            if (i_play_req[i]) w_req_idx = IDX_W'(i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_idx   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_ptr   <= w_ptr_nx;
            r_idx   <= w_idx_nx;
            r_done  <= w_done_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_ptr_nx   = r_ptr;
        w_idx_nx   = r_idx;
        w_done_nx  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_state_nx = ST_LOAD;
                    w_ptr_nx   = P_TUNE_START[w_req_idx];
                    w_idx_nx   = w_req_idx;
                end
            end
            ST_LOAD: w_state_nx = ST_PLAY;
            ST_PLAY: begin
                if (w_dur_hit) begin
                    if (r_last) begin
                        w_state_nx = ST_IDLE;
                        w_done_nx  = 1'b1;
                    end else begin
                        w_state_nx = ST_LOAD;
                        w_ptr_nx   = (r_ptr == PTR_W'(ROM_DEPTH - 1)) ? '0 : r_ptr + 1'b1;
                    end
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase
`ifdef PIEZO_PREEMPT_EN
        if ((r_state != ST_IDLE) && w_any_req && (w_req_idx > r_idx)) begin
            w_state_nx = ST_LOAD;
            w_ptr_nx   = P_TUNE_START[w_req_idx];
            w_idx_nx   = w_req_idx;
            w_done_nx  = 1'b0;
        end
`endif
        if (i_stop) begin
            w_state_nx = ST_IDLE;
            w_ptr_nx   = r_ptr;
            w_idx_nx   = r_idx;
            w_done_nx  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frq     <= '0;
            r_dur     <= '0;
            r_last    <= 1'b0;
            r_cnt_dur <= '0;
        end else begin
            if (r_state == ST_LOAD) begin
                r_frq  <= FRQ_W'(w_note.frq);
                r_dur  <= DUR_W'(w_note.dur);
                r_last <= w_note.last;
            end
            if ((r_state == ST_PLAY) && (w_state_nx == ST_PLAY))
                r_cnt_dur <= r_cnt_dur + DUR_INC;
            else
                r_cnt_dur <= '0;
        end
    end

    // On the LOAD->PLAY edge the tone block needs the incoming note's period,
    // which is only latched into r_frq on that same edge.
    assign w_tone_frq = (r_state == ST_LOAD) ? FRQ_W'(w_note.frq) : r_frq;
    assign w_tone_clr = (r_state == ST_LOAD) && (w_state_nx == ST_PLAY);
    assign w_tone_en  = (r_state == ST_PLAY) && (w_state_nx == ST_PLAY);

    piezo_tone #(.FRQ_W(FRQ_W)) u_tone (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_frq     (w_tone_frq),
        .i_clr     (w_tone_clr),
        .i_en      (w_tone_en),
        .o_piezo   (o_piezo),
        .o_piezo_n (o_piezo_n)
    );

    assign o_busy     = (r_state != ST_IDLE);
    assign o_tune_idx = r_idx;
    assign o_done     = r_done;

endmodule

// File: tb/tb_piezo_seq.sv
// tb_piezo_seq: self-checking bench for piezo_seq using a short note table.
// The reference model expands each tune into its expected per-cycle output
// trace {piezo, piezo_n, busy, done, tune_idx} straight from the note list.
module tb_piezo_seq;
    import piezo_pkg::*;

    function automatic rom_t tb_rom();
        rom_t r;
        r     = '0;
        r[0]  = '{frq: 15'd0,  dur: 25'd24, last: 1'b1};
        r[1]  = '{frq: 15'd6,  dur: 25'd40, last: 1'b0};
        r[2]  = '{frq: 15'd5,  dur: 25'd16, last: 1'b0};
        r[3]  = '{frq: 15'd8,  dur: 25'd33, last: 1'b0};
        r[4]  = '{frq: 15'd4,  dur: 25'd0,  last: 1'b0};
        r[5]  = '{frq: 15'd0,  dur: 25'd20, last: 1'b0};
        r[6]  = '{frq: 15'd7,  dur: 25'd50, last: 1'b1};
        r[14] = '{frq: 15'd3,  dur: 25'd30, last: 1'b0};
        r[15] = '{frq: 15'd10, dur: 25'd64, last: 1'b0};
        return r;
    endfunction

    localparam rom_t            TB_ROM   = tb_rom();
    localparam logic [1:0][3:0] TB_START = {4'd14, 4'd1};

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] play_req;
    logic       stop;
    logic       o_piezo, o_piezo_n, o_busy, o_done;
    logic [0:0] o_tune_idx;

    int         n_vec = 0;
    int         n_err = 0;
    logic [4:0] q[$];
    int         cur_idx = 0;
    int         pre;
    int         k;
    int         op;
    logic [1:0] pat;

    piezo_seq #(
        .NUM_TUNES(2), .FRQ_W(15), .DUR_W(25), .ROM_DEPTH(16), .FAST_SIM(1),
        .P_NOTE_ROM(TB_ROM), .P_TUNE_START(TB_START)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_play_req (play_req),
        .i_stop     (stop),
        .o_piezo    (o_piezo),
        .o_piezo_n  (o_piezo_n),
        .o_busy     (o_busy),
        .o_tune_idx (o_tune_idx),
        .o_done     (o_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [4:0] exp);
        logic [4:0] obs;
        obs = {o_piezo, o_piezo_n, o_busy, o_done, o_tune_idx};
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s obs=%b exp=%b (piezo,piezo_n,busy,done,idx)", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] idle_exp();
        logic [31:0] ci;
        ci = cur_idx;
        return {4'b0000, ci[0]};
    endfunction

    // Expected trace of tune t from its LOAD cycle up to and including the
    // IDLE cycle carrying the done pulse.
    task automatic plan_tune(input int t);
        int    ptr, f, d, len;
        bit    p, pn;
        note_t nt;
        logic [31:0] tv;
        tv      = t;
        ptr     = int'(TB_START[t]);
        cur_idx = t;
        for (int n = 0; n < 32; n++) begin
            q.push_back({4'b0010, tv[0]});
            nt  = TB_ROM[ptr];
            f   = int'(nt.frq);
            d   = int'(nt.dur);
            len = (d + 15) / 16 + 1;
            for (int c = 0; c < len; c++) begin
                p  = 1'b0;
                pn = 1'b0;
                if (f != 0) begin
                    p  = ((c % f) >= (f / 2));
                    pn = !p;
                end
                q.push_back({p, pn, 1'b1, 1'b0, tv[0]});
            end
            if (nt.last) begin
                q.push_back({4'b0001, tv[0]});
                break;
            end
            ptr = (ptr + 1) % 16;
        end
    endtask

    task automatic run_n(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            tick();
            if (q.size() == 0) chk({tag, "_empty"}, idle_exp());
            else chk(tag, q.pop_front());
        end
    endtask

    task automatic run_q(input string tag);
        run_n(q.size(), tag);
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            chk("idle", idle_exp());
        end
    endtask

    function automatic int hi(input logic [1:0] r);
        return r[1] ? 1 : 0;
    endfunction

    initial begin
        rst_n    = 1'b0;
        play_req = 2'b00;
        stop     = 1'b0;
        tick();
        tick();
        chk("reset", 5'b00000);
        rst_n = 1'b1;
        idle_n(1000);

        // fanfare-style tune 0, single-cycle request
        play_req = 2'b01;
        plan_tune(0);
        run_n(1, "t0_load");
        play_req = 2'b00;
        run_q("t0_play");
        idle_n(3);

        // both requested: tune 1 wins, wraps 15 -> 0, ends on a rest
        play_req = 2'b11;
        plan_tune(1);
        run_n(1, "t1_load");
        play_req = 2'b00;
        run_q("t1_play");
        idle_n(3);

        // stop and request on the same edge: stop wins, request next cycle
        play_req = 2'b01;
        stop     = 1'b1;
        tick();
        chk("stop_req_same", idle_exp());
        stop = 1'b0;
        plan_tune(0);
        run_n(1, "after_stop_load");
        play_req = 2'b00;
        run_q("after_stop_play");
        idle_n(2);

        // asynchronous reset in the middle of a tune
        play_req = 2'b10;
        plan_tune(1);
        run_n(1, "pre_rst_load");
        play_req = 2'b00;
        run_n(3, "pre_rst_play");
        rst_n = 1'b0;
        #1;
        cur_idx = 0;
        q.delete();
        chk("async_rst", 5'b00000);
        tick();
        rst_n = 1'b1;
        idle_n(2);

        for (int it = 0; it < 24; it++) begin
            op  = int'($urandom_range(0, 3));
            pat = 2'($urandom_range(1, 3));
            case (op)
                0: begin
                    play_req = pat;
                    plan_tune(hi(pat));
                    run_n(1, "rnd_load");
                    play_req = 2'b00;
                    run_q("rnd_play");
                end
                1: begin
                    play_req = pat;
                    plan_tune(hi(pat));
                    run_n(1, "stop_load");
                    play_req = 2'b00;
                    k = int'($urandom_range(0, q.size() - 2));
                    run_n(k, "stop_play");
                    stop = 1'b1;
                    q.delete();
                    tick();
                    chk("stop_idle", idle_exp());
                    stop = 1'b0;
                    tick();
                    chk("stop_no_done", idle_exp());
                end
                2: begin
                    play_req = 2'b01;
                    plan_tune(0);
                    run_n(1, "pre_load0");
                    play_req = 2'b00;
                    k = int'($urandom_range(0, q.size() - 2));
                    run_n(k, "pre_play0");
                    play_req = 2'b10;
`ifdef PIEZO_PREEMPT_EN
                    q.delete();
                    pre = 0;
`else
                    pre = q.size();
`endif
                    plan_tune(1);
                    run_n(pre + 1, "preempt_load1");
                    play_req = 2'b00;
                    run_q("preempt_play1");
                end
                default: begin
                    play_req = pat;
                    plan_tune(hi(pat));
                    pre = q.size();
                    plan_tune(hi(pat));
                    run_n(pre + 1, "replay_first");
                    play_req = 2'b00;
                    run_q("replay_second");
                end
            endcase
            idle_n(int'($urandom_range(1, 12)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
